// File: rtl/scarv_soc_pkg.sv
// rtl/scarv_soc_pkg.sv - shared types and widths for the SoC memif arbiter
package scarv_soc_pkg;

    localparam int MEMIF_ADDR_W = 32;
    localparam int MEMIF_DATA_W = 32;
    localparam int MEMIF_STRB_W = 4;

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCKED
    } arb_state_t;

    typedef logic master_id_t;

    localparam master_id_t MID_M0 = 1'b0;
    localparam master_id_t MID_M1 = 1'b1;

endpackage

// File: rtl/scarv_soc_arb_fifo.sv
// rtl/scarv_soc_arb_fifo.sv - ownership FIFO recording which master owns each outstanding request
module scarv_soc_arb_fifo
    import scarv_soc_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  master_id_t push_id,
    input  logic       pop,
    output logic       full,
    output logic       empty,
    output master_id_t head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    master_id_t       mem_q [DEPTH];
    master_id_t       mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        full     = (count_q == CNT_FULL);
        empty    = (count_q == '0);
        do_push  = push && !full;
        do_pop   = pop && !empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_id;
            wr_ptr_d        = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
        end
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    assign head = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= MID_M0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/scarv_soc_memif_arb.sv
// rtl/scarv_soc_memif_arb.sv - two-master round-robin memif arbiter with in-order response routing
module scarv_soc_memif_arb
    import scarv_soc_pkg::*;
#(
    parameter int OUTSTANDING       = 2,
    parameter bit M0_PRIORITY_RESET = 1'b1
) (
    input  logic                    f_clk,
    input  logic                    g_reset,
    input  logic                    m0_req,
    output logic                    m0_gnt,
    input  logic                    m0_wen,
    input  logic [MEMIF_STRB_W-1:0] m0_strb,
    input  logic [MEMIF_ADDR_W-1:0] m0_addr,
    input  logic [MEMIF_DATA_W-1:0] m0_wdata,
    output logic                    m0_recv,
    input  logic                    m0_ack,
    output logic                    m0_error,
    output logic [MEMIF_DATA_W-1:0] m0_rdata,
    input  logic                    m1_req,
    output logic                    m1_gnt,
    input  logic                    m1_wen,
    input  logic [MEMIF_STRB_W-1:0] m1_strb,
    input  logic [MEMIF_ADDR_W-1:0] m1_addr,
    input  logic [MEMIF_DATA_W-1:0] m1_wdata,
    output logic                    m1_recv,
    input  logic                    m1_ack,
    output logic                    m1_error,
    output logic [MEMIF_DATA_W-1:0] m1_rdata,
    output logic                    s_req,
    input  logic                    s_gnt,
    output logic                    s_wen,
    output logic [MEMIF_STRB_W-1:0] s_strb,
    output logic [MEMIF_ADDR_W-1:0] s_addr,
    output logic [MEMIF_DATA_W-1:0] s_wdata,
    input  logic                    s_recv,
    output logic                    s_ack,
    input  logic                    s_error,
    input  logic [MEMIF_DATA_W-1:0] s_rdata
);

    localparam master_id_t PRIO_RESET = M0_PRIORITY_RESET ? MID_M0 : MID_M1;

    arb_state_t state_q, state_d;
    master_id_t sel_q, sel_d;
    master_id_t prio_q, prio_d;
    master_id_t sel, head;
    logic       grant, fifo_full, fifo_empty, head_recv, pop;

    always_comb begin
        sel   = sel_q;
        s_req = 1'b0;
        if (state_q == ARB_LOCKED) begin
            s_req = 1'b1;
        end else begin
            if (m0_req && m1_req) sel = prio_q;
            else if (m1_req)      sel = MID_M1;
            else                  sel = MID_M0;
            // Full is judged on the registered count, so a same-cycle pop never frees a slot.
            s_req = (m0_req || m1_req) && !fifo_full;
        end
        grant   = s_req && s_gnt;
        m0_gnt  = grant && (sel == MID_M0);
        m1_gnt  = grant && (sel == MID_M1);
        s_wen   = (sel == MID_M1) ? m1_wen   : m0_wen;
        s_strb  = (sel == MID_M1) ? m1_strb  : m0_strb;
        s_addr  = (sel == MID_M1) ? m1_addr  : m0_addr;
        s_wdata = (sel == MID_M1) ? m1_wdata : m0_wdata;

        state_d = state_q;
        sel_d   = sel_q;
        prio_d  = prio_q;
        if (state_q == ARB_IDLE && s_req && !s_gnt) begin
            state_d = ARB_LOCKED;
            sel_d   = sel;
        end else if (state_q == ARB_LOCKED && s_gnt) begin
            state_d = ARB_IDLE;
        end
        if (grant) prio_d = ~sel;
    end

    always_comb begin
        head_recv = s_recv && !fifo_empty;
        m0_recv   = head_recv && (head == MID_M0);
        m1_recv   = head_recv && (head == MID_M1);
        m0_error  = m0_recv && s_error;
        m1_error  = m1_recv && s_error;
        m0_rdata  = m0_recv ? s_rdata : '0;
        m1_rdata  = m1_recv ? s_rdata : '0;
        s_ack     = !fifo_empty && ((head == MID_M1) ? m1_ack : m0_ack);
        pop       = s_recv && s_ack;
    end

    always_ff @(posedge f_clk) begin
        if (g_reset) begin
            state_q <= ARB_IDLE;
            sel_q   <= MID_M0;
            prio_q  <= PRIO_RESET;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            prio_q  <= prio_d;
        end
    end

    scarv_soc_arb_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_owner_fifo (
        .clk     (f_clk),
        .reset   (g_reset),
        .push    (grant),
        .push_id (sel),
        .pop     (pop),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .head    (head)
    );

    // A response with nothing outstanding has no owner and is dropped.
    assert property (@(posedge f_clk) disable iff (g_reset) !(s_recv && fifo_empty));

endmodule

// File: doc/scarv_soc_memif_arb.md
Name: scarv_soc_memif_arb

Overview:
- Two-master, one-slave arbiter for the SoC external memory interface (ccx memif request/grant + recv/ack protocol).
- Lets the core complex (M0) and a future DMA/debug master (M1) share the peripheral sub-system memif.
- Round-robin grant with a per-request ownership FIFO, so in-order responses route back to the originating master.
- Sits between scarv_ccx_top / DMA and scarv_soc_periph_top.

Parameters:
- OUTSTANDING, 2, max accepted-but-unresponded transactions; power of 2, range 1..8.
- M0_PRIORITY_RESET, 1, master that holds round-robin priority after reset (1 = M0 first).

Ports:
- f_clk  in  1  free-running clock.
- g_reset  in  1  synchronous, active-high reset.
- mX_req  in  1  master X request valid (X = 0, 1; applies to all mX_* lines).
- mX_gnt  out  1  request accepted this cycle.
- mX_wen  in  1  write enable.
- mX_strb  in  4  byte strobes.
- mX_addr  in  32  byte address.
- mX_wdata  in  32  write data.
- mX_recv  out  1  response valid.
- mX_ack  in  1  master accepts response.
- mX_error  out  1  response error.
- mX_rdata  out  32  read data.
- s_req  out  1  slave request valid.
- s_gnt  in  1  slave accepts request.
- s_wen, s_strb, s_addr, s_wdata  out  1/4/32/32  forwarded request fields.
- s_recv  in  1  slave response valid.
- s_ack  out  1  response accepted.
- s_error  in  1  response error.
- s_rdata  in  32  response read data.

Behaviour:
- Reset: all mX_gnt, mX_recv, s_req, s_ack = 0; mX_error, mX_rdata = 0 when not recv; FIFO empty; sel_lock = 0; priority = M0 if M0_PRIORITY_RESET = 1, else M1.
- Protocol rule: a master holds req and all fields stable until gnt. Transfer occurs on req & gnt. Response transfers on recv & ack.
- Arbitration state, 2 states:
  - IDLE: if FIFO not full, select the requesting master. If both request, select the priority master. Drive s_* combinationally from the selection. If s_gnt is 0, go LOCKED with sel held.
  - LOCKED: s_* stays driven from the held master, with no re-arbitration until s_gnt; then return to IDLE.
- mX_gnt = s_gnt & s_req & (sel == X), combinational. Zero added request latency.
- On every grant, push sel into the ownership FIFO and set priority to the non-selected master.
- FIFO full (count == OUTSTANDING): s_req forced 0 in IDLE, even if a pop occurs in the same cycle. Full is a registered decision.
- LOCKED entry only occurs with FIFO not full, so a locked request always completes.
- Response path:
  - head = FIFO head owner.
  - m[head]_recv = s_recv & !empty; m[head]_rdata/error = s_rdata/s_error. The other master sees recv = 0, rdata = 0.
  - s_ack = m[head]_ack & !empty.
  - Pop on s_recv & s_ack.
- s_recv while FIFO empty: s_ack = 0, response ignored. Protocol violation; assertion fires in simulation.
- Same-cycle push and pop: count unchanged; both pointers advance; pointers wrap modulo OUTSTANDING.
- Reset mid-transaction: FIFO and lock cleared immediately. The slave must be reset by the same g_reset.
- One-cycle grant-to-response (s_recv the cycle after s_gnt) is supported. Back-to-back grants to the same master are allowed when the other master is idle.

Decomposition:
- Package scarv_soc_pkg:
  - localparam typedef arb_state_t {ARB_IDLE, ARB_LOCKED}.
  - typedef master_id_t (1 bit).
  - Constants MEMIF_ADDR_W = 32, MEMIF_DATA_W = 32, MEMIF_STRB_W = 4.
- Sub-module scarv_soc_arb_fifo: parameterised-depth, master_id_t-wide synchronous FIFO with push/pop/full/empty/head. Used for ownership tracking.

Test Plan:
- Single master: M0 reads 0x1000_0004, slave gnt same cycle, recv next cycle with rdata 0xDEADBEEF -> m0_gnt=1 at cycle 0; m0_recv=1 with 0xDEADBEEF at cycle 1; m1_recv stays 0.
- Contention: M0 and M1 both request every cycle, slave always grants -> grants alternate M0, M1, M0, M1 from reset; no master granted twice while the other waits.
- Stall lock: M1 requests and s_gnt is held 0 for 3 cycles while M0 raises req -> s_addr stays at M1's address throughout; M1 is granted on cycle 4; M0 is granted next.
- Outstanding limit (OUTSTANDING=2): slave grants but delays all recv -> third request sees s_req=0 until the first response pops. Interleaved M0/M1 responses route in grant order; mX_ack=0 back-pressures s_ack.
- Error routing: slave returns s_error=1 to an M1 write at 0x1000_1000 -> m1_recv=1, m1_error=1; m0_error=0.
- Reset mid-operation: assert g_reset with 2 outstanding and LOCKED -> next cycle s_req=0, all recv=0, FIFO empty, priority at reset value.
